// File: rtl/f7_block_accumulator.sv
// f7_block_accumulator
//
// Decodes 7-bit float codes (e = code[6:4], m = code[3:0]) back to an 11-bit
// unsigned magnitude and accumulates blocks of them. For each block it
// produces a saturated sum, the largest decoded value, the number of codes,
// and a flag that is set if the sum saturated. One result is presented per
// block over a valid/ready handshake.
//
// Parameters:
//   BLOCK_LEN  codes per block (2..256)
//   SUM_W      accumulator / result sum width (11..24)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   in_code carries a code this cycle
//   in_ready   block accepts in_code this cycle
//   in_code    float code [6:4] exponent, [3:0] mantissa
//   flush      close the current partial block early
//   out_valid  result registers hold an unconsumed result
//   out_ready  downstream accepts the result
//   out_sum    block sum, saturated to all-ones
//   out_max    largest decoded value in the block
//   out_cnt    number of codes in the block
//   out_sat    sum saturated during the block

module f7_block_accumulator #(
  parameter int BLOCK_LEN = 16,
  parameter int SUM_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [10:0]      out_max,
  output logic [8:0]       out_cnt,
  output logic             out_sat
);

  typedef enum logic {ACCUM, EMIT} state_t;

  localparam logic [8:0] BLOCK_CNT = 9'(BLOCK_LEN);

  state_t           state, state_next;
  logic [SUM_W-1:0] acc, acc_next;
  logic [10:0]      max_val, max_next;
  logic [8:0]       cnt, cnt_next;
  logic             sat_flag, sat_next;

  logic             load_result;
  logic [SUM_W-1:0] load_sum;
  logic [10:0]      load_max;
  logic [8:0]       load_cnt;
  logic             load_sat;

  logic [2:0]       exp_f;
  logic [3:0]       man_f;
  logic [10:0]      value;
  logic [SUM_W:0]   sum_wide;
  logic [SUM_W-1:0] upd_acc;
  logic [10:0]      upd_max;
  logic [8:0]       upd_cnt;
  logic             upd_sat;
  logic             xfer;

  assign exp_f = in_code[6:4];
  assign man_f = in_code[3:0];

  // Exponent 0 is the denormal range (value = m); otherwise the hidden
  // leading one is restored and the 5-bit significand is shifted up.
  always_comb begin
    value = {7'b0, man_f};
    if (exp_f != 3'd0) begin
      value = {6'b0, 1'b1, man_f} << (exp_f - 3'd1);
    end
  end

  // in_ready never looks at in_valid, so there is no combinational loop
  // through an upstream stage that waits on in_ready.
  assign in_ready  = (state == ACCUM) || out_ready;
  assign out_valid = (state == EMIT);
  assign xfer      = in_valid && in_ready;

  // Block statistics as they would be after absorbing the current word.
  // The extra sum bit is the saturation detector.
  always_comb begin
    sum_wide = {1'b0, acc} + {{(SUM_W-10){1'b0}}, value};
    upd_acc  = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
    upd_sat  = sat_flag || sum_wide[SUM_W];
    upd_max  = (value > max_val) ? value : max_val;
    upd_cnt  = cnt + 9'd1;
  end

  // Next-state and datapath control. The running statistics are zero while
  // a result is held, so the release-cycle word simply starts a fresh block
  // from the same update path.
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    max_next    = max_val;
    cnt_next    = cnt;
    sat_next    = sat_flag;
    load_result = 1'b0;
    load_sum    = upd_acc;
    load_max    = upd_max;
    load_cnt    = upd_cnt;
    load_sat    = upd_sat;

    unique case (state)
      ACCUM: begin
        if (xfer) begin
          if ((upd_cnt == BLOCK_CNT) || flush) begin
            load_result = 1'b1;
            acc_next    = '0;
            max_next    = '0;
            cnt_next    = '0;
            sat_next    = 1'b0;
            state_next  = EMIT;
          end else begin
            acc_next = upd_acc;
            max_next = upd_max;
            cnt_next = upd_cnt;
            sat_next = upd_sat;
          end
        end else if (flush && (cnt != 9'd0)) begin
          load_result = 1'b1;
          load_sum    = acc;
          load_max    = max_val;
          load_cnt    = cnt;
          load_sat    = sat_flag;
          acc_next    = '0;
          max_next    = '0;
          cnt_next    = '0;
          sat_next    = 1'b0;
          state_next  = EMIT;
        end
      end
      EMIT: begin
        // Flush is ignored here; a block can never complete in the release
        // cycle because at most one word is taken.
        if (out_ready) begin
          state_next = ACCUM;
          if (xfer) begin
            acc_next = upd_acc;
            max_next = upd_max;
            cnt_next = upd_cnt;
            sat_next = upd_sat;
          end
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Running block statistics and result registers. Result registers only
  // change when a block completes, so they are stable during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      max_val  <= '0;
      cnt      <= '0;
      sat_flag <= 1'b0;
      out_sum  <= '0;
      out_max  <= '0;
      out_cnt  <= '0;
      out_sat  <= 1'b0;
    end else begin
      acc      <= acc_next;
      max_val  <= max_next;
      cnt      <= cnt_next;
      sat_flag <= sat_next;
      if (load_result) begin
        out_sum <= load_sum;
        out_max <= load_max;
        out_cnt <= load_cnt;
        out_sat <= load_sat;
      end
    end
  end

endmodule

// File: tb/tb_f7_block_accumulator.sv
// Testbench for f7_block_accumulator.
// Two instances run the same stimulus: one with BLOCK_LEN=16/SUM_W=16 and one
// with BLOCK_LEN=2/SUM_W=11 (saturating). A reference model keeps the words
// of the open block in a queue; when a block closes it computes the expected
// result with plain arithmetic and pushes it into a scoreboard queue. A
// separate monitor pops and compares whenever the DUT presents a result.

module tb_f7_block_accumulator;

  typedef struct {
    longint sum;
    int     max;
    int     cnt;
    int     sat;
    int     due;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Decoded magnitude straight from the code definition.
  function automatic int decode_ref(input logic [6:0] c);
    int e, m;
    e = int'(c[6:4]);
    m = int'(c[3:0]);
    if (e == 0) return m;
    return (16 + m) * (1 << (e - 1));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int BL = (g == 0) ? 16 : 2;
    localparam int SW = (g == 0) ? 16 : 11;

    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_code;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sum;
    logic [10:0]   out_max;
    logic [8:0]    out_cnt;
    logic          out_sat;

    exp_t q[$];
    int   words[$];
    bit   busy;
    bit   finished;

    f7_block_accumulator #(.BLOCK_LEN(BL), .SUM_W(SW)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_code(in_code),
      .flush(flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum(out_sum),
      .out_max(out_max),
      .out_cnt(out_cnt),
      .out_sat(out_sat)
    );

    // Close the model's open block and queue the expected result.
    task automatic close_block();
      exp_t   e;
      longint total;
      total = 0;
      e.max = 0;
      foreach (words[i]) begin
        total += longint'(words[i]);
        if (words[i] > e.max) e.max = words[i];
      end
      e.sat = (total >= (longint'(1) << SW)) ? 1 : 0;
      e.sum = (e.sat != 0) ? ((longint'(1) << SW) - 1) : total;
      e.cnt = words.size();
      e.due = cyc + 1;
      q.push_back(e);
      words.delete();
      busy = 1'b1;
    endtask

    // One clock of stimulus; the model predicts in_ready and the transfer.
    task automatic step(input bit v, input logic [6:0] c, input bit f, input bit r);
      bit exp_ready, was_busy, xfer;
      @(negedge clk);
      in_valid  = v;
      in_code   = c;
      flush     = f;
      out_ready = r;
      #1;
      was_busy  = busy;
      exp_ready = !was_busy || r;
      check($sformatf("i%0d in_ready", g), 64'(in_ready), 64'(exp_ready));
      xfer = v && exp_ready;
      if (was_busy && r) busy = 1'b0;
      if (xfer) words.push_back(decode_ref(c));
      if (!was_busy && (words.size() > 0) && ((words.size() == BL) || f)) close_block();
    endtask

    task automatic apply_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_code   = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      words.delete();
      q.delete();
      busy = 1'b0;
      #1;
      check($sformatf("i%0d reset out_valid", g), 64'(out_valid), 64'd0);
      check($sformatf("i%0d reset out_sum", g), 64'(out_sum), 64'd0);
      check($sformatf("i%0d reset out_max", g), 64'(out_max), 64'd0);
      check($sformatf("i%0d reset out_cnt", g), 64'(out_cnt), 64'd0);
      check($sformatf("i%0d reset out_sat", g), 64'(out_sat), 64'd0);
      check($sformatf("i%0d reset in_ready", g), 64'(in_ready), 64'd1);
    endtask

    // Monitor: pops a new expectation on each fresh result, and checks the
    // held result stays unchanged until it is consumed.
    initial begin
      bit   holding;
      bit   consumed;
      bit   rst_s;
      exp_t cur;
      holding = 1'b0;
      forever begin
        @(posedge clk);
        consumed = (out_valid === 1'b1) && (out_ready === 1'b1);
        rst_s    = (rst === 1'b1);
        #1;
        if (rst_s || consumed) holding = 1'b0;
        if (out_valid === 1'b1) begin
          if (!holding) begin
            if (q.size() == 0) begin
              check($sformatf("i%0d out_valid with empty scoreboard", g), 64'(out_valid), 64'd0);
            end else begin
              cur     = q.pop_front();
              holding = 1'b1;
              check($sformatf("i%0d result cycle", g), 64'(cyc), 64'(cur.due));
              check($sformatf("i%0d out_sum", g), 64'(out_sum), 64'(cur.sum));
              check($sformatf("i%0d out_max", g), 64'(out_max), 64'(cur.max));
              check($sformatf("i%0d out_cnt", g), 64'(out_cnt), 64'(cur.cnt));
              check($sformatf("i%0d out_sat", g), 64'(out_sat), 64'(cur.sat));
            end
          end else begin
            check($sformatf("i%0d held out_sum", g), 64'(out_sum), 64'(cur.sum));
            check($sformatf("i%0d held out_max", g), 64'(out_max), 64'(cur.max));
            check($sformatf("i%0d held out_cnt", g), 64'(out_cnt), 64'(cur.cnt));
            check($sformatf("i%0d held out_sat", g), 64'(out_sat), 64'(cur.sat));
          end
        end
      end
    end

    // Stimulus sequence.
    initial begin
      logic [6:0] sweep [3];
      sweep[0]  = 7'h03;
      sweep[1]  = 7'h15;
      sweep[2]  = 7'h7F;
      finished  = 1'b0;
      busy      = 1'b0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_code   = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      apply_reset();

      // Decode sweep, pairs back to back.
      for (int i = 0; i < 3; i++) begin
        step(1'b1, sweep[i], 1'b0, 1'b1);
        step(1'b1, 7'h00, 1'b1, 1'b1);
      end
      step(1'b0, 7'h00, 1'b0, 1'b1);

      // Largest code for a full 16-word run.
      for (int i = 0; i < 16; i++) step(1'b1, 7'h7F, 1'b0, 1'b1);
      step(1'b0, 7'h00, 1'b0, 1'b1);
      step(1'b0, 7'h00, 1'b0, 1'b1);

      // Small block right after a saturated one.
      step(1'b1, 7'h01, 1'b0, 1'b1);
      step(1'b1, 7'h01, 1'b1, 1'b1);
      step(1'b0, 7'h00, 1'b0, 1'b1);

      // Flush with a word, then flushes on an empty block.
      step(1'b1, 7'h10, 1'b0, 1'b1);
      step(1'b1, 7'h20, 1'b1, 1'b1);
      step(1'b0, 7'h00, 1'b0, 1'b1);
      step(1'b0, 7'h00, 1'b1, 1'b1);
      step(1'b0, 7'h00, 1'b1, 1'b1);
      step(1'b0, 7'h00, 1'b0, 1'b1);

      // Backpressure: full block, 5-cycle stall, release with a new word.
      for (int i = 0; i < BL; i++) step(1'b1, 7'($urandom), 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 7'($urandom), 1'b0, 1'b0);
      step(1'b1, 7'h15, 1'b0, 1'b1);
      step(1'b1, 7'h03, 1'b1, 1'b1);
      step(1'b0, 7'h00, 1'b0, 1'b1);

      // Reset mid-block, then reset while a result is held.
      for (int i = 0; i < 5; i++) step(1'b1, 7'($urandom), 1'b0, 1'b1);
      apply_reset();
      for (int i = 0; i < BL; i++) step(1'b1, 7'($urandom), 1'b0, 1'b0);
      apply_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 7'h01, 1'b0, 1'b1);
      step(1'b0, 7'h00, 1'b0, 1'b1);
      step(1'b0, 7'h00, 1'b0, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
        step($urandom_range(0, 3) != 0, 7'($urandom), $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) != 0);
      end

      // Drain outstanding results.
      for (int i = 0; i < 4; i++) step(1'b0, 7'h00, 1'b0, 1'b1);
      for (int i = 0; (i < 50) && (q.size() != 0); i++) @(negedge clk);
      check($sformatf("i%0d scoreboard drained", g), 64'(q.size()), 64'd0);
      finished = 1'b1;
    end
  end

  initial begin
    for (int i = 0; (i < 40000) && !(inst[0].finished && inst[1].finished); i++) @(posedge clk);
    check("run completes", 64'(inst[0].finished && inst[1].finished), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
